// File: rtl/rsa_modexp_scheduler.sv
// Shared modular-exponentiation engine for the RSA encrypt and decrypt paths.
// Round-robin arbitration, left-to-right square-and-multiply, bit-serial restoring reduction.
module rsa_modexp_scheduler #(
    parameter int DATA_W = 8,
    parameter int EXP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_req,
    input  logic [DATA_W-1:0] enc_base,
    input  logic [EXP_W-1:0]  enc_exp,
    input  logic              dec_req,
    input  logic [DATA_W-1:0] dec_base,
    input  logic [EXP_W-1:0]  dec_exp,
    input  logic [DATA_W-1:0] modulus,
    output logic              enc_ack,
    output logic              dec_ack,
    output logic              busy,
    output logic              done,
    output logic              resp_id,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    localparam int CNT_W = (2 * DATA_W > 1) ? $clog2(2 * DATA_W) : 1;
    localparam int KW    = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * DATA_W - 1);
    localparam logic [KW-1:0]    K_TOP    = KW'(EXP_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        RED_BASE,
        MUL,
        RED,
        DONE
    } state_t;

    state_t              state;
    logic [2*DATA_W-1:0] p;
    logic [DATA_W:0]     r;
    logic [DATA_W-1:0]   m;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   breg;
    logic [EXP_W-1:0]    e;
    logic [CNT_W-1:0]    cnt;
    logic [KW-1:0]       kbit;
    logic                is_mul;
    logic                owner;
    logic                ptr;
    logic                bad_mod;

    logic                grant_enc;
    logic                grant_dec;
    logic                any_grant;
    logic [DATA_W-1:0]   sel_base;
    logic [EXP_W-1:0]    sel_exp;
    logic [DATA_W:0]     r_sh;
    logic [DATA_W:0]     r_nx;
    logic [DATA_W-1:0]   acc_nx;

    // ptr=0 favours enc; after a grant it points at the other requester
    always_comb begin
        grant_enc = enc_req && (!dec_req || !ptr);
        grant_dec = dec_req && !grant_enc;
        any_grant = grant_enc || grant_dec;
        sel_base  = grant_dec ? dec_base : enc_base;
        sel_exp   = grant_dec ? dec_exp : enc_exp;
    end

    // One restoring step: R < M before the shift, so R fits DATA_W+1 bits after it
    always_comb begin
        r_sh = (r << 1) | {{DATA_W{1'b0}}, p[2*DATA_W-1]};
        r_nx = (r_sh >= {1'b0, m}) ? (r_sh - {1'b0, m}) : r_sh;
        acc_nx = (!is_mul || e[kbit]) ? r_nx[DATA_W-1:0] : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            p       <= '0;
            r       <= '0;
            m       <= '0;
            acc     <= '0;
            breg    <= '0;
            e       <= '0;
            cnt     <= '0;
            kbit    <= '0;
            is_mul  <= 1'b0;
            owner   <= 1'b0;
            ptr     <= 1'b0;
            bad_mod <= 1'b0;
            enc_ack <= 1'b0;
            dec_ack <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            resp_id <= 1'b0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            enc_ack <= 1'b0;
            dec_ack <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (any_grant) begin
                        state   <= RED_BASE;
                        busy    <= 1'b1;
                        enc_ack <= grant_enc;
                        dec_ack <= grant_dec;
                        owner   <= grant_dec;
                        ptr     <= grant_enc;
                        p       <= {{DATA_W{1'b0}}, sel_base};
                        r       <= '0;
                        cnt     <= '0;
                        m       <= modulus;
                        e       <= sel_exp;
                        bad_mod <= (modulus < DATA_W'(2));
                        kbit    <= K_TOP;
                        is_mul  <= 1'b0;
                        acc     <= DATA_W'(1);
                    end
                end
                RED_BASE: begin
                    if (bad_mod) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        result  <= '0;
                        err     <= 1'b1;
                        resp_id <= owner;
                    end else begin
                        r   <= r_nx;
                        p   <= p << 1;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            breg  <= r_nx[DATA_W-1:0];
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    p     <= (2*DATA_W)'(acc) * (2*DATA_W)'(is_mul ? breg : acc);
                    r     <= '0;
                    cnt   <= '0;
                    state <= RED;
                end
                RED: begin
                    r   <= r_nx;
                    p   <= p << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        acc <= acc_nx;
                        if (!is_mul) begin
                            is_mul <= 1'b1;
                            state  <= MUL;
                        end else if (kbit == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            result  <= acc_nx;
                            err     <= 1'b0;
                            resp_id <= owner;
                        end else begin
                            kbit   <= kbit - 1'b1;
                            is_mul <= 1'b0;
                            state  <= MUL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_scheduler.sv
// Self-checking bench for rsa_modexp_scheduler: vector table, scoreboard queue,
// arbitration, bad-modulus and mid-operation reset sequences.
module tb_rsa_modexp_scheduler;

    localparam int DATA_W = 8;
    localparam int EXP_W  = 4;
    localparam int LAT    = 152;

    logic              clk = 1'b0;
    logic              rst;
    logic              enc_req, dec_req;
    logic [DATA_W-1:0] enc_base, dec_base, modulus;
    logic [EXP_W-1:0]  enc_exp, dec_exp;
    logic              enc_ack, dec_ack, busy, done, resp_id, err;
    logic [DATA_W-1:0] result;

    rsa_modexp_scheduler #(.DATA_W(DATA_W), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst),
        .enc_req(enc_req), .enc_base(enc_base), .enc_exp(enc_exp),
        .dec_req(dec_req), .dec_base(dec_base), .dec_exp(dec_exp),
        .modulus(modulus),
        .enc_ack(enc_ack), .dec_ack(dec_ack), .busy(busy), .done(done),
        .resp_id(resp_id), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              is_dec;
        logic [DATA_W-1:0] base;
        logic [EXP_W-1:0]  exp;
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] res;
        logic              err;
    } vec_t;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] res;
        logic              err;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] model(input int b, input int e, input int m);
        int acc;
        if (m < 2) return '0;
        acc = 1;
        for (int i = 0; i < e; i++) acc = (acc * b) % m;
        return DATA_W'(acc);
    endfunction

    task automatic push_exp(input logic id, input logic [DATA_W-1:0] res, input logic e);
        exp_t x;
        x.id = id; x.res = res; x.err = e;
        sbq.push_back(x);
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        x = sbq.pop_front();
        check({tag, "_resp_id"}, resp_id, x.id);
        check({tag, "_result"}, result, x.res);
        check({tag, "_err"}, err, x.err);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again
    task automatic run_op(input string tag, input logic is_dec, input logic [DATA_W-1:0] b,
                          input logic [EXP_W-1:0] e, input logic [DATA_W-1:0] m,
                          input logic [DATA_W-1:0] want, input logic want_err);
        int n;
        bit seen;
        push_exp(is_dec, want, want_err);
        modulus = m;
        if (is_dec) begin dec_base = b; dec_exp = e; dec_req = 1'b1; end
        else        begin enc_base = b; enc_exp = e; enc_req = 1'b1; end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if ((is_dec ? dec_ack : enc_ack) === 1'b1) seen = 1;
        end
        enc_req = 1'b0;
        dec_req = 1'b0;
        if (!seen) begin
            check({tag, "_ack_timeout"}, 0, 1);
            void'(sbq.pop_front());
            return;
        end
        check({tag, "_other_ack"}, is_dec ? enc_ack : dec_ack, 0);
        check({tag, "_busy_at_ack"}, busy, 1);
        enc_base = 8'hA5; dec_base = 8'h5A; enc_exp = 4'h9; dec_exp = 4'h6; modulus = 8'h07;
        n = 0;
        seen = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, "_ack_pulse"}, enc_ack | dec_ack, 0);
            if (done === 1'b1) seen = 1;
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
            void'(sbq.pop_front());
            return;
        end
        check({tag, "_latency"}, n, (m < 2) ? 1 : LAT);
        check({tag, "_busy_at_done"}, busy, 1);
        pop_check(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_result_hold"}, result, want);
    endtask

    vec_t vecs[9];

    initial begin
        int n, n_done, n_ack, last_done, order_ok;
        logic exp_owner[3];
        logic [DATA_W-1:0] rb, rm;
        logic [EXP_W-1:0] re;
        logic rd;

        vecs[0] = '{1'b0, 8'd2,   4'd5,  8'd33, 8'd32, 1'b0};
        vecs[1] = '{1'b0, 8'd4,   4'd3,  8'd33, 8'd31, 1'b0};
        vecs[2] = '{1'b1, 8'd31,  4'd7,  8'd33, 8'd4,  1'b0};
        vecs[3] = '{1'b0, 8'd200, 4'd0,  8'd13, 8'd1,  1'b0};
        vecs[4] = '{1'b0, 8'd200, 4'd1,  8'd13, 8'd5,  1'b0};
        vecs[5] = '{1'b1, 8'd200, 4'd15, 8'd13, 8'd8,  1'b0};
        vecs[6] = '{1'b0, 8'd9,   4'd3,  8'd0,  8'd0,  1'b1};
        vecs[7] = '{1'b1, 8'd9,   4'd3,  8'd1,  8'd0,  1'b1};
        vecs[8] = '{1'b0, 8'd7,   4'd2,  8'd11, 8'd5,  1'b0};

        rst = 1'b1;
        enc_req = 1'b0; dec_req = 1'b0;
        enc_base = '0; dec_base = '0; enc_exp = '0; dec_exp = '0; modulus = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {enc_ack, dec_ack, busy, done, resp_id, result, err}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].is_dec, vecs[i].base, vecs[i].exp,
                   vecs[i].m, vecs[i].res, vecs[i].err);

        for (int i = 0; i < 4; i++) begin
            rd = 1'($urandom_range(0, 1));
            rb = 8'($urandom_range(0, 255));
            re = 4'($urandom_range(0, 15));
            rm = 8'($urandom_range(2, 255));
            run_op($sformatf("rnd%0d", i), rd, rb, re, rm, model(rb, re, rm), 1'b0);
        end

        // Both requesters held high from reset: expect enc, dec, enc
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enc_base = 8'd2; enc_exp = 4'd5; dec_base = 8'd31; dec_exp = 4'd7; modulus = 8'd33;
        exp_owner[0] = 1'b0; exp_owner[1] = 1'b1; exp_owner[2] = 1'b0;
        push_exp(1'b0, 8'd32, 1'b0);
        push_exp(1'b1, 8'd4, 1'b0);
        push_exp(1'b0, 8'd32, 1'b0);
        enc_req = 1'b1; dec_req = 1'b1;
        n_done = 0; n_ack = 0; last_done = -10; order_ok = 1;
        for (int cyc = 0; cyc < 700 && n_done < 3; cyc++) begin
            @(negedge clk);
            if (enc_ack && dec_ack) check("rr_double_ack", 1, 0);
            if (enc_ack || dec_ack) begin
                if (n_ack < 3) check($sformatf("rr_grant%0d", n_ack), dec_ack, exp_owner[n_ack]);
                else check("rr_extra_ack", n_ack, 2);
                if (n_ack > 0) check($sformatf("rr_ack%0d_after_done", n_ack), cyc, last_done + 1);
                n_ack++;
                if (n_ack == 3) begin enc_req = 1'b0; dec_req = 1'b0; end
            end
            if (done) begin
                pop_check($sformatf("rr_done%0d", n_done));
                last_done = cyc;
                n_done++;
            end
        end
        enc_req = 1'b0; dec_req = 1'b0;
        check("rr_done_count", n_done, 3);
        check("rr_ack_count", n_ack, 3);
        sbq.delete();
        @(negedge clk);

        // Reset 80 edges into an operation aborts it silently
        enc_base = 8'd3; enc_exp = 4'd7; modulus = 8'd50; enc_req = 1'b1;
        n = 0;
        while (!enc_ack && n < 10) begin @(negedge clk); n++; end
        enc_req = 1'b0;
        check("abort_ack_seen", enc_ack, 1);
        repeat (80) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs", {enc_ack, dec_ack, busy, done, resp_id, result, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (200) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_op("post_abort", 1'b0, 8'd3, 4'd7, 8'd50, model(3, 7, 50), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_scheduler.md
Name: rsa_modexp_scheduler

Overview:
- Sequential modular-exponentiation engine shared between the RSA encrypt path and the decrypt path. Each path requests a computation of base^exp mod modulus.
- A round-robin arbiter grants one request at a time.
- An FSM runs left-to-right square-and-multiply on one shared 8x8 multiplier and a bit-serial restoring reducer.
- Replaces the combinational power/mod chain with a fixed-latency, registered datapath.

Parameters:
- DATA_W, 8, width of base, modulus and result
- EXP_W, 4, exponent width (key width)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- enc_req  in  1  encrypt request; hold high until enc_ack
- enc_base  in  DATA_W  encrypt base (message)
- enc_exp  in  EXP_W  encrypt exponent (e)
- dec_req  in  1  decrypt request; hold high until dec_ack
- dec_base  in  DATA_W  decrypt base (ciphertext)
- dec_exp  in  EXP_W  decrypt exponent (d)
- modulus  in  DATA_W  shared modulus n, sampled at accept
- enc_ack  out  1  one-cycle pulse: encrypt request accepted
- dec_ack  out  1  one-cycle pulse: decrypt request accepted
- busy  out  1  high from accept until the DONE cycle inclusive
- done  out  1  one-cycle pulse: result valid
- resp_id  out  1  owner of current result: 0=enc, 1=dec
- result  out  DATA_W  base^exp mod modulus; holds until next done
- err  out  1  modulus<2 for current result; valid with done, holds

Behaviour:
- Reset (async): state=IDLE. Arbiter pointer favours enc. All outputs 0. Any in-flight operation is aborted silently; no done is produced.
- Accept: on a clk edge in IDLE with any req high, grant one request.
  - Simultaneous requests: grant the requester not granted last. Pointer toggles only on a grant.
  - Sample base, exp and modulus into internal registers. Enter RED_BASE.
  - Next cycle: the matching ack=1 and busy=1. Requests arriving while busy stay pending and are not acked.
- States: IDLE, RED_BASE, MUL, RED, DONE.
- Datapath:
  - Product register P is 2*DATA_W bits; remainder register R is DATA_W+1 bits.
  - RED: 2*DATA_W iterations, one per cycle, MSB of P first: R = (R<<1)|P[i]; if R>=M then R = R-M.
  - RED_BASE reduces the zero-extended base into breg.
- Operation sequence (acc=1 initially): for each exponent bit k from EXP_W-1 down to 0:
  - Square op: MUL cycle P = acc*acc, then RED; acc = R.
  - Multiply op: MUL cycle P = acc*breg, then RED; acc = R only if exp[k]=1, otherwise discard.
  - Both ops always execute, so latency is data-independent.
- Latency: 2*DATA_W + 2*EXP_W*(1+2*DATA_W) edges from the accept edge to entering DONE. This is 152 with defaults.
  - done=1 for exactly the DONE cycle; result=acc, resp_id=owner, err=0.
  - Then return to IDLE. A pending request can be accepted on that edge.
- Modulus 0 or 1 at accept: skip computation; the next edge enters DONE with result=0, err=1.
- exp=0: result=1 (M>=2). base>=M: reduced correctly by RED_BASE.
- result, resp_id and err are registered and hold between done pulses. ack and done never overlap for the same operation.
- Operand ports may change after ack; they are not used after the accept edge.

Test Plan:
- Reset, enc_req with base=2, exp=5, M=33 -> enc_ack 1 cycle later; done exactly 152 edges after accept; result=32, resp_id=0, err=0.
- RSA round trip with n=33, e=3, d=7:
  - enc base=4 -> result=31.
  - Then dec base=31 -> result=4, resp_id=1.
- enc_req and dec_req both held high from reset over three rounds -> grants enc, dec, enc. The second ack comes on the edge after the first done cycle; no double ack.
- Edge values with M=13, base=200:
  - exp=0 -> result=1.
  - exp=1 -> result=5.
  - exp=15 -> 5^15 mod 13 = 8.
- M=0, then M=1 -> done one cycle after ack each time, result=0, err=1. A following valid request clears err.
- Assert rst at edge 80 of an operation -> all outputs 0 immediately. No done occurs. A new enc request then completes normally with the correct result.
